// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
// Holds the state encoding and the default word width.
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH bit position counter with clear, enable and terminal-count flag.
// Clear has priority over enable so that an accept restarts the count at bit 0.
module bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: accepts a WIDTH-bit word and shifts it out one bit
// per clock with valid/busy/done framing; back-to-back words stream without a gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic             x_q;
    logic             valid_q;
    logic             done_q;
    logic             ready_q;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             accept;
    logic             shifting;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // ready_q is a registered flag, so accept never depends combinationally on outputs.
    assign accept   = load & ready_q;
    assign shifting = (state_q == ST_SHIFT);

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (shifting),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // Outputs are computed one cycle ahead so every output port comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            x_q     <= IDLE_BIT;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else if (accept) begin
            state_q <= ST_SHIFT;
            sreg_q  <= drop_first(data_in);
            x_q     <= first_bit(data_in);
            valid_q <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else if (shifting) begin
            if (cnt_tc) begin
                state_q <= ST_IDLE;
                x_q     <= IDLE_BIT;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                sreg_q  <= drop_first(sreg_q);
                x_q     <= first_bit(sreg_q);
                done_q  <= (cnt == CNT_PENULT);
                ready_q <= (cnt == CNT_PENULT);
            end
        end
    end

    assign ready     = ready_q;
    assign x_out     = x_q;
    assign bit_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first (idle 0) and LSB-first (idle 1) instances in parallel,
// checked every cycle against a word-queue reference model plus directed vectors.
module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;

    logic rdy_m, x_m, bv_m, busy_m, done_m;
    logic rdy_l, x_l, bv_l, busy_l, done_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .ready(rdy_m), .x_out(x_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .ready(rdy_l), .x_out(x_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of (word, bit index) slots; the slot at the head is on the wire.
    typedef struct {
        logic [W-1:0] w;
        int           idx;
        bit           v;
    } slot_t;

    slot_t pend[$];
    slot_t cur = '{w: '0, idx: 0, v: 1'b0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            cur.v = 1'b0;
        end else begin
            if (load && (!cur.v || cur.idx == W - 1)) begin
                for (int i = 0; i < W; i++) pend.push_back('{w: data_in, idx: i, v: 1'b1});
            end
            if (pend.size() > 0) cur = pend.pop_front();
            else cur.v = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic e_done, e_rdy, e_xm, e_xl;
        e_done = cur.v && (cur.idx == W - 1);
        e_rdy  = !cur.v || e_done;
        e_xm   = cur.v ? cur.w[W - 1 - cur.idx] : 1'b0;
        e_xl   = cur.v ? cur.w[cur.idx] : 1'b1;
        chk("model_x_msb", x_m, e_xm);
        chk("model_x_lsb", x_l, e_xl);
        chk("model_valid_msb", bv_m, cur.v);
        chk("model_valid_lsb", bv_l, cur.v);
        chk("model_busy_msb", busy_m, cur.v);
        chk("model_busy_lsb", busy_l, cur.v);
        chk("model_done_msb", done_m, e_done);
        chk("model_done_lsb", done_l, e_done);
        chk("model_ready_msb", rdy_m, e_rdy);
        chk("model_ready_lsb", rdy_l, e_rdy);
    end

    logic sm [1:32];
    logic sl [1:32];
    logic sv [1:32];
    logic sd [1:32];
    logic sr [1:32];

    task automatic step(input int k);
        @(negedge clk);
        sm[k] = x_m;
        sl[k] = x_l;
        sv[k] = bv_m;
        sd[k] = done_m;
        sr[k] = rdy_m;
    endtask

    typedef struct {
        logic [W-1:0] w;
        logic [W-1:0] msb_stream;
        logic [W-1:0] lsb_stream;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] got;
        int pulses, where;

        vecs[0] = '{8'hB4, 8'b1011_0100, 8'b0010_1101};
        vecs[1] = '{8'hFF, 8'b1111_1111, 8'b1111_1111};
        vecs[2] = '{8'h01, 8'b0000_0001, 8'b1000_0000};
        vecs[3] = '{8'h5A, 8'b0101_1010, 8'b0101_1010};
        vecs[4] = '{8'hC3, 8'b1100_0011, 8'b1100_0011};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", rdy_m, 1'b1);
        chk("rst_x_msb", x_m, 1'b0);
        chk("rst_x_lsb", x_l, 1'b1);
        chk("rst_valid", bv_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        rst = 1'b0;

        // Table vectors; the first accept lands on the first edge after reset release
        for (int v = 0; v < 5; v++) begin
            load = 1'b1;
            data_in = vecs[v].w;
            for (int k = 1; k <= 9; k++) begin
                step(k);
                if (k == 1) load = 1'b0;
                data_in = W'($urandom);
            end
            for (int k = 1; k <= 8; k++) begin
                chk("tbl_msb_bit", sm[k], vecs[v].msb_stream[8 - k]);
                chk("tbl_lsb_bit", sl[k], vecs[v].lsb_stream[8 - k]);
                chk("tbl_valid", sv[k], 1'b1);
                chk("tbl_done", sd[k], (k == 8));
            end
            chk("tbl_idle_valid", sv[9], 1'b0);
            chk("tbl_idle_x", sm[9], 1'b0);
        end

        // Back-to-back: FF then 00 accepted during the last bit
        load = 1'b1;
        data_in = 8'hFF;
        for (int k = 1; k <= 17; k++) begin
            step(k);
            if (k == 1) load = 1'b0;
            if (k == 8) begin load = 1'b1; data_in = 8'h00; end
            if (k == 9) load = 1'b0;
        end
        for (int k = 1; k <= 16; k++) begin
            chk("b2b_valid", sv[k], 1'b1);
            chk("b2b_bit", sm[k], (k <= 8));
            chk("b2b_done", sd[k], (k == 8 || k == 16));
        end
        chk("b2b_end_valid", sv[17], 1'b0);

        // Loads while busy are dropped, not queued
        load = 1'b1;
        data_in = 8'h0F;
        for (int k = 1; k <= 10; k++) begin
            step(k);
            if (k == 1) load = 1'b0;
            if (k == 2) begin load = 1'b1; data_in = 8'hAA; end
            if (k == 7) load = 1'b0;
        end
        for (int k = 1; k <= 8; k++) got[8 - k] = sm[k];
        chk("busy_load_stream", got, 8'h0F);
        for (int k = 1; k <= 8; k++) chk("busy_load_ready", sr[k], (k == 8));
        chk("busy_load_no_queue", sv[9] | sv[10], 1'b0);

        // Asynchronous reset during bit 4 of C3
        load = 1'b1;
        data_in = 8'hC3;
        for (int k = 1; k <= 4; k++) begin
            step(k);
            if (k == 1) load = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x", x_m, 1'b0);
        chk("async_rst_x_lsb", x_l, 1'b1);
        chk("async_rst_valid", bv_m, 1'b0);
        chk("async_rst_busy", busy_m, 1'b0);
        chk("async_rst_done", done_m, 1'b0);
        chk("async_rst_ready", rdy_m, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            step(k);
            if (sd[k] || sv[k]) pulses++;
        end
        chk("async_rst_no_done", pulses, 0);
        load = 1'b1;
        data_in = 8'hC3;
        for (int k = 1; k <= 9; k++) begin
            step(k);
            if (k == 1) load = 1'b0;
        end
        for (int k = 1; k <= 8; k++) got[8 - k] = sm[k];
        chk("post_rst_stream", got, 8'hC3);

        // Downstream 1-to-0 detector on 0110_0000
        load = 1'b1;
        data_in = 8'b0110_0000;
        for (int k = 1; k <= 9; k++) begin
            step(k);
            if (k == 1) load = 1'b0;
        end
        pulses = 0;
        where = -1;
        for (int k = 2; k <= 8; k++) begin
            if (sv[k] && sv[k - 1] && sm[k - 1] && !sm[k]) begin
                pulses++;
                where = k - 1;
            end
        end
        chk("detector_pulses", pulses, 1);
        chk("detector_index", where, 3);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            load = ($urandom_range(0, 2) == 0);
            data_in = W'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
REQ-003 Parameter IDLE_BIT, default 0: x_out level whenever no word is being shifted.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, asynchronous and active-high; clears all state.
REQ-006 data_in  input  WIDTH  parallel word; sampled only on accept.
REQ-007 load  input  1  word-valid request from the producer.
REQ-008 ready  output  1  serializer can accept a word this cycle.
REQ-009 x_out  output  1  serial bit stream to the downstream sequence detector.
REQ-010 bit_valid  output  1  x_out carries a data bit this cycle.
REQ-011 busy  output  1  a word is in flight.
REQ-012 done  output  1  single-cycle pulse during the last bit of each word.

Function
REQ-013 The block SHALL accept a word on a rising edge where load=1 and ready=1; load with ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-014 The block SHALL implement a two-state machine: IDLE -> SHIFT on accept; SHIFT -> IDLE after bit WIDTH-1 with no new accept; SHIFT -> SHIFT on an accept during the last bit.
REQ-015 The block SHALL present the first bit on x_out in the cycle after accept, with one-cycle latency from accept.
REQ-016 The block SHALL shift one bit per clock for exactly WIDTH consecutive cycles, with bit_valid=1 and busy=1 throughout.
REQ-017 A bit counter SHALL run 0..WIDTH-1 and clear on accept; width SHALL be clog2(WIDTH).
REQ-018 ready SHALL be 1 in IDLE and in the last-bit cycle of SHIFT (counter = WIDTH-1), and 0 otherwise.
REQ-019 An accept during the last-bit cycle SHALL start the next word's first bit in the next cycle, giving a gapless stream with bit_valid held at 1.
REQ-020 done SHALL be 1 only in the cycle carrying bit WIDTH-1 of a word, regardless of whether a new word was accepted in that cycle.
REQ-021 In IDLE, x_out SHALL equal IDLE_BIT, and bit_valid, busy and done SHALL be 0.
REQ-022 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from load or data_in to any output.
REQ-023 Changes to data_in after accept SHALL NOT affect the word in flight.

Reset
REQ-024 On rst=1, independent of clk, the block SHALL force: state=IDLE, counter=0, shift register=0, x_out=IDLE_BIT, bit_valid=0, busy=0, done=0, ready=1.
REQ-025 Reset asserted mid-word SHALL discard the remaining bits, and no done pulse SHALL be emitted for that word.
REQ-026 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant.
REQ-028 One sub-module SHALL be used: bit_counter, a WIDTH-modulo counter with clear, enable and terminal-count outputs; all other logic SHALL be inline.
REQ-029 The design SHALL be a single clock domain with no latches.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, accept 8'hB4 -> x_out = 1,0,1,1,0,1,0,0 on cycles 1..8; bit_valid=1 on cycles 1..8; done=1 on cycle 8 only; IDLE_BIT from cycle 9.
REQ-031 MSB_FIRST=0, accept 8'hB4 -> x_out = 0,0,1,0,1,1,0,1; done on cycle 8.
REQ-032 Accept 8'hFF, then accept 8'h00 on cycle 8 -> 16 contiguous bit_valid cycles: eight 1s then eight 0s; done on cycles 8 and 16.
REQ-033 Hold load=1 with 8'hAA from cycle 2 through cycle 6 while shifting 8'h0F -> those requests are ignored; the output stream is 8'h0F only; ready=1 only on cycle 8.
REQ-034 Assert rst asynchronously mid-cycle at bit 4 of 8'hC3 -> outputs go to reset values immediately; no done pulse; a fresh accept after release serializes correctly.
REQ-035 Drive the stream into the downstream sequence detector with word 8'b0110_0000 -> the detector output pulses once, at the 1-to-0 transition (bit index 3).
